// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register built as a 2-entry skid buffer.
//
// The head register drives the memory-stage outputs. The skid register takes
// one extra entry when the head is stalled. This lets in_ready come straight
// from a flop, so there is no combinational path from out_ready.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high on the same side (in_valid & in_ready, out_valid & out_ready).
// While out_valid is high and out_ready is low, the out_* payload is held.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   flush           synchronous discard of all held entries (beats push/pop)
//   in_valid/ready  upstream ALU handshake
//   in_result/flags/rd/reg_write   incoming ALU entry
//   out_valid/ready memory-stage handshake
//   out_result/flags/rd/reg_write  head-entry payload
//   occupancy       number of held entries (0..2); also the FSM state code
module ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_flags,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_flags,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_reg_write,
  output logic [1:0]        occupancy
);

  // The state code equals the entry count, so occupancy exposes the FSM
  // state directly.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [3:0]        flags;
    logic [RD_W-1:0]   rd;
    logic              reg_write;
  } entry_t;

  state_t state, state_next;
  entry_t head_q, skid_q, in_entry;
  logic   in_ready_q;
  logic   push, pop;
  logic   head_load, head_from_skid, skid_load;

  // Register x0 is never written, so drop the write enable when the entry
  // is captured.
  always_comb begin
    in_entry.result    = in_result;
    in_entry.flags     = in_flags;
    in_entry.rd        = in_rd;
    in_entry.reg_write = in_reg_write && (in_rd != '0);
  end

  // A push is blocked during flush. Any entry offered in that cycle is
  // discarded.
  assign push = in_valid && in_ready_q && !flush;
  assign pop  = (state != S_EMPTY) && out_ready;

  // State register. in_ready is registered from the next state, so it is
  // valid from the start of each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != S_FULL);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = S_EMPTY;
    end else begin
      unique case (state)
        S_EMPTY: if (push) state_next = S_ONE;
        S_ONE: begin
          if (push && !pop)      state_next = S_FULL;
          else if (!push && pop) state_next = S_EMPTY;
        end
        // In FULL, in_ready is low, so only a pop can happen.
        S_FULL:  if (pop) state_next = S_ONE;
        default: state_next = S_EMPTY;
      endcase
    end
  end

  // Datapath load enables
  always_comb begin
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (!flush) begin
      head_load      = push && ((state == S_EMPTY) || ((state == S_ONE) && pop));
      head_from_skid = (state == S_FULL) && pop;
      skid_load      = push && (state == S_ONE) && !pop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (head_load)           head_q <= in_entry;
      else if (head_from_skid) head_q <= skid_q;
      if (skid_load)           skid_q <= in_entry;
    end
  end

  // Output logic
  always_comb begin
    out_valid     = (state != S_EMPTY);
    in_ready      = in_ready_q;
    occupancy     = state;
    out_result    = head_q.result;
    out_flags     = head_q.flags;
    out_rd        = head_q.rd;
    out_reg_write = head_q.reg_write;
  end

endmodule
